// File: rtl/lotr_pkg.sv
//------------------------------------------------------------------------------
// Module  : lotr_pkg
// Brief   : Shared fabric opcodes and UART bridge frame byte codes.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package lotr_pkg;

  typedef enum logic [1:0] {
    RD     = 2'b00,
    RD_RSP = 2'b01,
    WR     = 2'b10,
    WR_RSP = 2'b11
  } t_opcode;

  localparam logic [7:0] UART_CMD_RD   = 8'hA1;
  localparam logic [7:0] UART_CMD_WR   = 8'hA2;
  localparam logic [7:0] UART_RSP_DATA = 8'h5A;
  localparam logic [7:0] UART_RSP_ACK  = 8'hA5;
  localparam logic [7:0] UART_RSP_ERR  = 8'hEE;

endpackage

`default_nettype wire

// File: rtl/uart_fabric_bridge_if.sv
//------------------------------------------------------------------------------
// Module  : uart_fabric_bridge_if
// Brief   : Gateway byte streams plus C2F request/response port of the bridge.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_fabric_bridge_if;
  import lotr_pkg::*;

  logic          rx_byte_valid;
  logic [7:0]    rx_byte;
  logic          rx_byte_ready;
  logic          tx_byte_valid;
  logic [7:0]    tx_byte;
  logic          tx_byte_ready;

  logic          C2F_ReqValidQ500H;
  t_opcode       C2F_ReqOpcodeQ500H;
  logic [31:0]   C2F_ReqAddressQ500H;
  logic [31:0]   C2F_ReqDataQ500H;
  logic [1:0]    C2F_ReqThreadIDQ500H;
  logic          C2F_RspValidQ502H;
  t_opcode       C2F_RspOpcodeQ502H;
  logic [31:0]   C2F_RspDataQ502H;
  logic [1:0]    C2F_RspThreadIDQ502H;
  logic          C2F_RspStall;

  // Bridge side
  modport master (
    input  rx_byte_valid, rx_byte, tx_byte_ready,
    output rx_byte_ready, tx_byte_valid, tx_byte,
    output C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqAddressQ500H,
           C2F_ReqDataQ500H, C2F_ReqThreadIDQ500H,
    input  C2F_RspValidQ502H, C2F_RspOpcodeQ502H, C2F_RspDataQ502H,
           C2F_RspThreadIDQ502H, C2F_RspStall
  );

  // Gateway / fabric side
  modport slave (
    output rx_byte_valid, rx_byte, tx_byte_ready,
    input  rx_byte_ready, tx_byte_valid, tx_byte,
    input  C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqAddressQ500H,
           C2F_ReqDataQ500H, C2F_ReqThreadIDQ500H,
    output C2F_RspValidQ502H, C2F_RspOpcodeQ502H, C2F_RspDataQ502H,
           C2F_RspThreadIDQ502H, C2F_RspStall
  );

endinterface

`default_nettype wire

// File: rtl/uart_fabric_bridge_frame_tx.sv
//------------------------------------------------------------------------------
// Module  : uart_frame_tx
// Brief   : Serialises a loaded frame of 1..5 bytes, first byte in bits 39:32.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_frame_tx (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_load,
  input  wire logic [2:0]  i_len,
  input  wire logic [39:0] i_frame,
  output logic             o_tx_valid,
  output logic [7:0]       o_tx_byte,
  input  wire logic        i_tx_ready,
  output logic             o_done
);

  logic [39:0] r_buf;
  logic [2:0]  r_left;
  logic        r_valid;
  logic        w_fire;

  assign w_fire     = r_valid && i_tx_ready;
  assign o_done     = w_fire && (r_left == 3'd1);
  assign o_tx_valid = r_valid;
  assign o_tx_byte  = r_buf[39:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf   <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_buf   <= i_frame;
      r_left  <= i_len;
      r_valid <= (i_len != 3'd0);
    end else if (w_fire) begin
      r_buf  <= {r_buf[31:0], 8'h00};
      r_left <= r_left - 3'd1;
      if (r_left == 3'd1) r_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_fabric_bridge.sv
//------------------------------------------------------------------------------
// Module  : uart_fabric_bridge
// Brief   : UART byte-frame to C2F request bridge for host peek/poke access.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_fabric_bridge
  import lotr_pkg::*;
#(
  parameter logic [15:0] FRAME_TIMEOUT = 16'd50000,
  parameter logic [15:0] RSP_TIMEOUT   = 16'd1024,
  parameter logic [1:0]  THREAD_ID     = 2'd3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  uart_fabric_bridge_if.master  bus,
  output logic [7:0]            err_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_DATA     = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_RSP = 3'd4,
    S_TX       = 3'd5
  } t_ufb_state;

  localparam logic [15:0] c_frame_last = FRAME_TIMEOUT - 16'd1;
  localparam logic [15:0] c_rsp_last   = RSP_TIMEOUT - 16'd1;

  t_ufb_state  r_state, w_state_next;
  logic [31:0] r_addr, r_data;
  logic        r_is_write;
  logic [1:0]  r_byte_cnt;
  logic [15:0] r_idle_cnt, r_rsp_cnt;
  logic [7:0]  r_err_count;

  logic        w_rx_ready, w_rx_fire, w_rsp_hit, w_issue, w_tx_done;
  logic        w_tx_load, w_err_inc;
  logic [2:0]  w_tx_len;
  logic [39:0] w_tx_frame;

  assign w_rx_ready = !rst && (r_state == S_IDLE || r_state == S_ADDR || r_state == S_DATA);
  assign w_rx_fire  = bus.rx_byte_valid && w_rx_ready;
  assign w_rsp_hit  = bus.C2F_RspValidQ502H && (bus.C2F_RspOpcodeQ502H == RD_RSP) &&
                      (bus.C2F_RspThreadIDQ502H == THREAD_ID);
  assign w_issue    = (r_state == S_ISSUE);

  assign bus.rx_byte_ready        = w_rx_ready;
  assign bus.C2F_ReqValidQ500H    = w_issue && !bus.C2F_RspStall;
  assign bus.C2F_ReqOpcodeQ500H   = (w_issue && r_is_write) ? WR : RD;
  assign bus.C2F_ReqAddressQ500H  = w_issue ? r_addr : '0;
  assign bus.C2F_ReqDataQ500H     = (w_issue && r_is_write) ? r_data : '0;
  assign bus.C2F_ReqThreadIDQ500H = w_issue ? THREAD_ID : 2'd0;
  assign err_count                = r_err_count;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_load    = 1'b0;
    w_tx_len     = 3'd0;
    w_tx_frame   = '0;
    w_err_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rx_fire) begin
          if (bus.rx_byte == UART_CMD_RD || bus.rx_byte == UART_CMD_WR) begin
            w_state_next = S_ADDR;
          end else begin
            w_tx_load    = 1'b1;
            w_tx_len     = 3'd1;
            w_tx_frame   = {UART_RSP_ERR, 32'h0};
            w_err_inc    = 1'b1;
            w_state_next = S_TX;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (w_rx_fire) begin
          if (r_byte_cnt == 2'd3)
            w_state_next = (r_state == S_ADDR && r_is_write) ? S_DATA : S_ISSUE;
        end else if (r_idle_cnt == c_frame_last) begin
          // Stalled host: drop the partial frame silently
          w_err_inc    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!bus.C2F_RspStall) begin
          if (r_is_write) begin
            w_tx_load    = 1'b1;
            w_tx_len     = 3'd1;
            w_tx_frame   = {UART_RSP_ACK, 32'h0};
            w_state_next = S_TX;
          end else begin
            w_state_next = S_WAIT_RSP;
          end
        end
      end
      S_WAIT_RSP: begin
        if (w_rsp_hit) begin
          w_tx_load    = 1'b1;
          w_tx_len     = 3'd5;
          w_tx_frame   = {UART_RSP_DATA, bus.C2F_RspDataQ502H};
          w_state_next = S_TX;
        end else if (r_rsp_cnt == c_rsp_last) begin
          w_tx_load    = 1'b1;
          w_tx_len     = 3'd1;
          w_tx_frame   = {UART_RSP_ERR, 32'h0};
          w_err_inc    = 1'b1;
          w_state_next = S_TX;
        end
      end
      S_TX: begin
        if (w_tx_done) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_is_write  <= 1'b0;
      r_byte_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_rsp_cnt   <= '0;
      r_err_count <= '0;
    end else begin
      if (w_rx_fire) begin
        r_idle_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            r_is_write <= (bus.rx_byte == UART_CMD_WR);
            r_byte_cnt <= '0;
          end
          S_ADDR: begin
            r_addr     <= {r_addr[23:0], bus.rx_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          S_DATA: begin
            r_data     <= {r_data[23:0], bus.rx_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          default: r_byte_cnt <= r_byte_cnt;
        endcase
      end else if (r_state == S_ADDR || r_state == S_DATA) begin
        r_idle_cnt <= r_idle_cnt + 16'd1;
      end

      if (r_state == S_WAIT_RSP) r_rsp_cnt <= r_rsp_cnt + 16'd1;
      else                       r_rsp_cnt <= '0;

      if (w_err_inc && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
  end

  uart_frame_tx u_frame_tx (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tx_load),
    .i_len      (w_tx_len),
    .i_frame    (w_tx_frame),
    .o_tx_valid (bus.tx_byte_valid),
    .o_tx_byte  (bus.tx_byte),
    .i_tx_ready (bus.tx_byte_ready),
    .o_done     (w_tx_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_fabric_bridge.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_fabric_bridge
// Brief   : Directed scoreboard bench for the UART fabric bridge.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_fabric_bridge;
  import lotr_pkg::*;

  localparam logic [15:0] c_frame_to = 16'd60;
  localparam logic [15:0] c_rsp_to   = 16'd40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] err_count;

  uart_fabric_bridge_if bif ();

  uart_fabric_bridge #(
    .FRAME_TIMEOUT (c_frame_to),
    .RSP_TIMEOUT   (c_rsp_to),
    .THREAD_ID     (2'd3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q[$];
  int          req_seen = 0;
  t_opcode     req_op;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_tid;
  logic        s_tx_valid, s_rx_fire;
  logic [7:0]  s_tx_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, return just after the next rising edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    s_tx_valid = bif.tx_byte_valid;
    s_tx_byte  = bif.tx_byte;
    s_rx_fire  = bif.rx_byte_valid && bif.rx_byte_ready;
    if (bif.C2F_ReqValidQ500H) begin
      req_seen++;
      req_op   = bif.C2F_ReqOpcodeQ500H;
      req_addr = bif.C2F_ReqAddressQ500H;
      req_data = bif.C2F_ReqDataQ500H;
      req_tid  = bif.C2F_ReqThreadIDQ500H;
    end
    if (bif.tx_byte_valid) begin
      if (bif.tx_byte_ready) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL tx_unexpected observed=0x%0h expected=none", bif.tx_byte);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tx_byte", {24'h0, bif.tx_byte}, {24'h0, e});
        end
      end else if (exp_q.size() != 0) begin
        chk("tx_hold", {24'h0, bif.tx_byte}, {24'h0, exp_q[0]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bif.rx_byte_valid = 1'b1;
    bif.rx_byte       = b;
    s_rx_fire         = 1'b0;
    for (int i = 0; i < 200 && !s_rx_fire; i++) tick();
    bif.rx_byte_valid = 1'b0;
    chk("rx_accept", {31'h0, s_rx_fire}, 32'h1);
  endtask

  task automatic send_bytes(input logic [71:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_req(input int n);
    for (int i = 0; i < 100 && req_seen < n; i++) tick();
    chk("req_count", req_seen, n);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
    chk("tx_drain", exp_q.size(), 0);
    tick();
  endtask

  task automatic drive_rsp(input t_opcode op, input logic [1:0] tid, input logic [31:0] d);
    bif.C2F_RspValidQ502H    = 1'b1;
    bif.C2F_RspOpcodeQ502H   = op;
    bif.C2F_RspThreadIDQ502H = tid;
    bif.C2F_RspDataQ502H     = d;
    tick();
    bif.C2F_RspValidQ502H    = 1'b0;
  endtask

  task automatic push_data(input logic [31:0] d);
    exp_q.push_back(8'h5A);
    for (int i = 3; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rdy_pat;
    rdy_pat = 4'b1001;
    bif.rx_byte_valid = 1'b0;
    bif.rx_byte = 8'h00;
    bif.tx_byte_ready = 1'b1;
    bif.C2F_RspValidQ502H = 1'b0;
    bif.C2F_RspOpcodeQ502H = RD;
    bif.C2F_RspDataQ502H = '0;
    bif.C2F_RspThreadIDQ502H = 2'd0;
    bif.C2F_RspStall = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rx_ready", {31'h0, bif.rx_byte_ready}, 32'h0);
    chk("rst_tx_valid", {31'h0, bif.tx_byte_valid}, 32'h0);
    chk("rst_tx_byte", {24'h0, bif.tx_byte}, 32'h0);
    chk("rst_req_valid", {31'h0, bif.C2F_ReqValidQ500H}, 32'h0);
    chk("rst_req_addr", bif.C2F_ReqAddressQ500H, 32'h0);
    chk("rst_err", {24'h0, err_count}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Write frame
    exp_q.push_back(8'hA5);
    send_bytes(72'hA2_10000040_DEADBEEF, 9);
    wait_req(1);
    chk("wr_op", {30'h0, req_op}, {30'h0, WR});
    chk("wr_addr", req_addr, 32'h1000_0040);
    chk("wr_data", req_data, 32'hDEAD_BEEF);
    chk("wr_tid", {30'h0, req_tid}, 32'h3);
    wait_drain(20);
    chk("wr_one_pulse", req_seen, 1);

    // Read frame, wrong-thread response first, ready toggling 1-0-0-1
    send_bytes({32'h0, 40'hA1_10000040}, 5);
    wait_req(2);
    chk("rd_op", {30'h0, req_op}, {30'h0, RD});
    chk("rd_addr", req_addr, 32'h1000_0040);
    chk("rd_data", req_data, 32'h0);
    chk("rd_tid", {30'h0, req_tid}, 32'h3);
    tick();
    drive_rsp(RD_RSP, 2'd1, 32'hBADB_AD00);
    tick();
    push_data(32'h1234_5678);
    drive_rsp(RD_RSP, 2'd3, 32'h1234_5678);
    tick();
    chk("rd_tx_latency_valid", {31'h0, s_tx_valid}, 32'h1);
    chk("rd_tx_latency_byte", {24'h0, s_tx_byte}, 32'h5A);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      bif.tx_byte_ready = rdy_pat[3 - (i % 4)];
      tick();
    end
    bif.tx_byte_ready = 1'b1;
    chk("rd_drain", exp_q.size(), 0);
    tick();
    chk("rd_rx_ready_after", {31'h0, bif.rx_byte_ready}, 32'h1);

    // Stall during ISSUE
    bif.C2F_RspStall = 1'b1;
    exp_q.push_back(8'hA5);
    send_bytes(72'hA2_00000008_01020304, 9);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("stall_no_req", req_seen, 2);
      chk("stall_addr", bif.C2F_ReqAddressQ500H, 32'h8);
      chk("stall_op", {30'h0, bif.C2F_ReqOpcodeQ500H}, {30'h0, WR});
    end
    bif.C2F_RspStall = 1'b0;
    wait_req(3);
    chk("stall_data", req_data, 32'h0102_0304);
    wait_drain(20);
    chk("stall_one_pulse", req_seen, 3);

    // Inter-byte timeout
    send_bytes({48'h0, 24'hA1_1000}, 3);
    repeat (int'(c_frame_to) + 5) tick();
    chk("to_no_req", req_seen, 3);
    chk("to_err", {24'h0, err_count}, 32'h1);
    chk("to_rx_ready", {31'h0, bif.rx_byte_ready}, 32'h1);
    send_bytes({32'h0, 40'hA1_00000100}, 5);
    wait_req(4);
    chk("to_next_addr", req_addr, 32'h0000_0100);
    tick();
    tick();
    push_data(32'hCAFE_F00D);
    drive_rsp(RD_RSP, 2'd3, 32'hCAFE_F00D);
    wait_drain(20);

    // Unknown command byte
    exp_q.push_back(8'hEE);
    send_byte(8'h33);
    wait_drain(20);
    chk("unk_err", {24'h0, err_count}, 32'h2);

    // Read with no response
    exp_q.push_back(8'hEE);
    send_bytes({32'h0, 40'hA1_00000004}, 5);
    wait_req(5);
    wait_drain(int'(c_rsp_to) + 50);
    chk("rsp_to_err", {24'h0, err_count}, 32'h3);

    // Response outside WAIT_RSP
    drive_rsp(RD_RSP, 2'd3, 32'h1111_1111);
    repeat (5) tick();
    chk("stray_rsp_no_tx", {31'h0, s_tx_valid}, 32'h0);
    chk("stray_rsp_err", {24'h0, err_count}, 32'h3);

    // Reset in the middle of a response frame
    send_bytes({32'h0, 40'hA1_00000020}, 5);
    wait_req(6);
    tick();
    bif.tx_byte_ready = 1'b0;
    drive_rsp(RD_RSP, 2'd3, 32'h5566_7788);
    tick();
    chk("midtx_valid", {31'h0, s_tx_valid}, 32'h1);
    chk("midtx_byte", {24'h0, s_tx_byte}, 32'h5A);
    rst = 1'b1;
    tick();
    tick();
    chk("midtx_rst_valid", {31'h0, s_tx_valid}, 32'h0);
    chk("midtx_rst_err", {24'h0, err_count}, 32'h0);
    rst = 1'b0;
    bif.tx_byte_ready = 1'b1;
    tick();
    chk("post_rst_rx_ready", {31'h0, bif.rx_byte_ready}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_fabric_bridge.md
# uart_fabric_bridge

Byte-level command bridge between the UART gateway's byte stream and the core fabric's C2F request/response port. Received bytes are assembled into read/write command frames, issued as one C2F request each, and answered with a short response frame back to the gateway for UART transmit. Lets an external host peek/poke any fabric address over the UART.

## Interface
- FRAME_TIMEOUT, 16'd50000: max idle cycles between bytes of one frame before discard
- RSP_TIMEOUT, 16'd1024: max cycles waiting for a read response
- THREAD_ID, 2'd3: thread ID stamped on requests and matched on responses
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rx_byte_valid / rx_byte / rx_byte_ready  in/in/out  1/8/1  byte stream from gateway (valid/ready)
- tx_byte_valid / tx_byte / tx_byte_ready  out/out/in  1/8/1  byte stream to gateway (valid/ready)
- C2F_ReqValidQ500H / ReqOpcodeQ500H / ReqAddressQ500H / ReqDataQ500H / ReqThreadIDQ500H  out  1/t_opcode/32/32/2  fabric request
- C2F_RspValidQ502H / RspOpcodeQ502H / RspDataQ502H / RspThreadIDQ502H  in  1/t_opcode/32/2  fabric response
- C2F_RspStall  in  1  fabric cannot accept a request this cycle
- err_count  out  8  saturating count of discarded/failed frames

## Operation
- Frames, multi-byte fields MSB first: read = 0xA1 + 4 addr bytes (5 B); write = 0xA2 + 4 addr + 4 data (9 B).
- Responses: read OK = 0x5A + 4 data bytes MSB first; write = 0xA5 (posted, sent once request issued); error = 0xEE.
- States: IDLE -> ADDR (cmd accepted) -> DATA (write only, after 4 addr bytes) -> ISSUE -> WAIT_RSP (read) or TX -> IDLE.
- IDLE, unknown command byte: consume, send 0xEE, err_count++, stay in IDLE after TX.
- ADDR/DATA: byte counter 0..3 shifts into addr/data registers; 4th byte advances state.
- Inter-byte counter resets on every accepted byte; reaching FRAME_TIMEOUT in ADDR/DATA -> IDLE, frame dropped, err_count++, no response byte.
- ISSUE: drive request (opcode RD or WR, addr, data, THREAD_ID; data = 0 for RD); retry every cycle while C2F_RspStall = 1.
- WAIT_RSP: accept only RspValid with opcode RD_RSP and RspThreadID == THREAD_ID; capture data, go TX with 0x5A frame. Other responses ignored. RSP_TIMEOUT elapsed -> TX 0xEE, err_count++.
- Responses arriving outside WAIT_RSP are ignored.
- err_count saturates at 255.

## Timing
- Reset values: rx_byte_ready 0, tx_byte_valid 0, tx_byte 0, all C2F_Req* 0, err_count 0, state IDLE, counters 0.
- rx_byte_ready = 1 exactly in IDLE, ADDR, DATA; byte taken on valid & ready rising edge.
- C2F_ReqValidQ500H = 1 for exactly one cycle: the ISSUE cycle with C2F_RspStall = 0; opcode/addr/data/thread stable while in ISSUE.
- Request accepted at cycle N -> write ack 0xA5 valid at N+1; read -> state WAIT_RSP at N+1.
- Matching response at cycle M -> tx_byte_valid = 1 with 0x5A at M+1.
- TX: tx_byte/tx_byte_valid held until tx_byte_ready; next byte presented cycle after handshake; no gaps when ready stays high. Last handshake -> IDLE, rx_byte_ready = 1 next cycle.
- rst mid-frame or mid-TX: immediate return to IDLE, partial frame and pending TX discarded, err_count cleared.
- Minimum fabric read latency is 2 cycles; no same-cycle request/response case.

## Structure
- lotr_pkg: UART_CMD_RD 8'hA1, UART_CMD_WR 8'hA2, UART_RSP_DATA 8'h5A, UART_RSP_ACK 8'hA5, UART_RSP_ERR 8'hEE; t_opcode reused.
- State enum t_ufb_state local to the module.
- One sub-module: uart_frame_tx, loads up to 5 bytes + length, serialises on tx valid/ready, returns done.

## Test plan
- Write 0xA2 10 00 00 40 DE AD BE EF -> one ReqValid, WR, addr 0x1000_0040, data 0xDEADBEEF, thread 3; tx 0xA5.
- Read 0xA1 10 00 00 40, RD_RSP data 0x12345678 after 5 cycles -> tx 0x5A 12 34 56 78; wrong-thread response before it ignored.
- C2F_RspStall high 7 cycles during ISSUE -> no ReqValid until stall drops, then exactly one pulse.
- 0xA1 10 00 then silence FRAME_TIMEOUT cycles -> no request, no tx, err_count 1; next valid frame works.
- Byte 0x33 in IDLE -> tx 0xEE, err_count +1; read with no response -> 0xEE after RSP_TIMEOUT.
- tx_byte_ready toggling 1-0-0-1 during 0x5A frame -> bytes held, order preserved; rst mid-TX -> tx_byte_valid 0 next cycle.
